// File: rtl/data_cache_core.sv
`default_nettype none
// ============================================================================
//  Module   : data_cache_core
//  Purpose  : Blocking, fully associative, write-back / write-allocate L1
//             data cache for the memory stage. Hits answer combinationally in
//             the request cycle; a miss stalls (dcache_ready low), writes back
//             a dirty victim, fetches the line and then replays the access.
//  Ports    : clock, reset (async active-low)
//             req_*              core request (valid/addr/store/word/data)
//             rsp_valid/rsp_data access completion and load data
//             dcache_ready       idle and accepting requests
//             xcpt_address_fault misaligned word access
//             req_*_miss         request to memory (fill or write-back)
//             rsp_*_miss         fill data return
//  Options  : DCACHE_VERBOSE_EN  simulation-only event trace ($display)
//  Revision : 1.0  initial release
// ============================================================================
module data_cache_core #(
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 128,
  parameter int NUM_LINES = 4,
  parameter int ACC_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  output logic              dcache_ready,
  output logic              xcpt_address_fault,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_is_store,
  input  logic              req_size_word,
  input  logic [ACC_W-1:0]  req_data,
  output logic              rsp_valid,
  output logic [ACC_W-1:0]  rsp_data,
  output logic              req_valid_miss,
  output logic [ADDR_W-1:0] req_addr_miss,
  output logic              req_is_store_miss,
  output logic [LINE_W-1:0] req_data_miss,
  input  logic [LINE_W-1:0] rsp_data_miss,
  input  logic              rsp_valid_miss
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EVICT  = 2'd1,
    S_FILL   = 2'd2,
    S_REPLAY = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_LINES-1:0]    valid_q, dirty_q;
  logic [TAG_W-1:0]        tag_q  [NUM_LINES];
  logic [LINE_W-1:0]       line_q [NUM_LINES];
  logic [ADDR_W-1:0]       addr_q;
  logic                    is_store_q, size_word_q;
  logic [ACC_W-1:0]        wdata_q;
  logic [IDX_W-1:0]        victim_q, rr_q;

  // Lookup and victim selection
  logic                    hit;
  logic [IDX_W-1:0]        hit_idx;
  logic                    inv_found;
  logic [IDX_W-1:0]        inv_idx, miss_victim;

  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    inv_found = 1'b0;
    inv_idx   = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (valid_q[i] && (tag_q[i] == req_addr[ADDR_W-1:4])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
    // Descending scan so the lowest-index invalid line wins.
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        inv_found = 1'b1;
        inv_idx   = IDX_W'(i);
      end
    end
  end

  assign miss_victim = inv_found ? inv_idx : rr_q;

  // Shared access datapath: the IDLE hit path and the REPLAY path use the
  // same load extraction / store merge, fed either live or from the latch.
  logic                    acc_replay;
  logic [3:0]              acc_off;
  logic                    acc_word;
  logic [ACC_W-1:0]        acc_wdata;
  logic [IDX_W-1:0]        acc_idx;
  logic [LINE_W-1:0]       acc_line, merged_line;
  logic [ACC_W-1:0]        load_data;

  assign acc_replay = (state_q == S_REPLAY);
  assign acc_off    = acc_replay ? addr_q[3:0] : req_addr[3:0];
  assign acc_word   = acc_replay ? size_word_q : req_size_word;
  assign acc_wdata  = acc_replay ? wdata_q     : req_data;
  assign acc_idx    = acc_replay ? victim_q    : hit_idx;
  assign acc_line   = line_q[acc_idx];

  always_comb begin
    merged_line = acc_line;
    if (acc_word) begin
      load_data = acc_line[{acc_off[3:2], 5'b00000} +: ACC_W];
      merged_line[{acc_off[3:2], 5'b00000} +: ACC_W] = acc_wdata;
    end else begin
      load_data = {{(ACC_W-8){1'b0}}, acc_line[{acc_off, 3'b000} +: 8]};
      merged_line[{acc_off, 3'b000} +: 8] = acc_wdata[7:0];
    end
  end

  // Control FSM: next state and outputs
  logic do_miss, do_fill, store_write;

  always_comb begin
    state_d            = state_q;
    dcache_ready       = 1'b0;
    xcpt_address_fault = 1'b0;
    rsp_valid          = 1'b0;
    rsp_data           = '0;
    req_valid_miss     = 1'b0;
    req_addr_miss      = '0;
    req_is_store_miss  = 1'b0;
    req_data_miss      = '0;
    do_miss            = 1'b0;
    do_fill            = 1'b0;
    store_write        = 1'b0;
    case (state_q)
      S_IDLE: begin
        dcache_ready       = 1'b1;
        xcpt_address_fault = req_valid & req_size_word & (|req_addr[1:0]);
        if (req_valid && !xcpt_address_fault) begin
          if (hit) begin
            rsp_valid   = 1'b1;
            rsp_data    = req_is_store ? '0 : load_data;
            store_write = req_is_store;
          end else begin
            do_miss = 1'b1;
            state_d = (valid_q[miss_victim] && dirty_q[miss_victim]) ? S_EVICT : S_FILL;
          end
        end
      end
      S_EVICT: begin
        req_valid_miss    = 1'b1;
        req_is_store_miss = 1'b1;
        req_addr_miss     = {tag_q[victim_q], 4'b0000};
        req_data_miss     = line_q[victim_q];
        state_d           = S_FILL;
      end
      S_FILL: begin
        req_valid_miss = 1'b1;
        req_addr_miss  = {addr_q[ADDR_W-1:4], 4'b0000};
        if (rsp_valid_miss) begin
          do_fill = 1'b1;
          state_d = S_REPLAY;
        end
      end
      S_REPLAY: begin
        rsp_valid   = 1'b1;
        rsp_data    = is_store_q ? '0 : load_data;
        store_write = is_store_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state (async reset)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      rr_q        <= '0;
      victim_q    <= '0;
      addr_q      <= '0;
      is_store_q  <= 1'b0;
      size_word_q <= 1'b0;
      wdata_q     <= '0;
    end else begin
      state_q <= state_d;
      if (do_miss) begin
        addr_q      <= req_addr;
        is_store_q  <= req_is_store;
        size_word_q <= req_size_word;
        wdata_q     <= req_data;
        victim_q    <= miss_victim;
        // Pointer only advances when an occupied line had to be displaced.
        if (!inv_found) rr_q <= rr_q + 1'b1;
      end
      if (do_fill) begin
        valid_q[victim_q] <= 1'b1;
        dirty_q[victim_q] <= 1'b0;
      end
      if (store_write) dirty_q[acc_idx] <= 1'b1;
    end
  end

  // Tag and data storage; contents are qualified by valid_q, so no reset.
  always_ff @(posedge clock) begin
    if (do_fill) begin
      line_q[victim_q] <= rsp_data_miss;
      tag_q[victim_q]  <= addr_q[ADDR_W-1:4];
    end else if (store_write) begin
      line_q[acc_idx] <= merged_line;
    end
  end

`ifdef DCACHE_VERBOSE_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      if (state_q == S_IDLE && req_valid && !xcpt_address_fault && hit)
        $display("[dcache] hit  addr=%h %s", req_addr, req_is_store ? "store" : "load");
      if (do_miss)
        $display("[dcache] miss addr=%h victim=%0d", req_addr, miss_victim);
      if (state_q == S_EVICT)
        $display("[dcache] evict addr=%h", req_addr_miss);
      if (do_fill)
        $display("[dcache] fill done addr=%h", req_addr_miss);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_cache_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_cache_core
//  Purpose  : Directed self-checking bench for data_cache_core
//  Revision : 1.0  initial release
// ============================================================================
module tb_data_cache_core;

  logic         clock;
  logic         reset;
  logic         dcache_ready;
  logic         xcpt_address_fault;
  logic         req_valid;
  logic [31:0]  req_addr;
  logic         req_is_store;
  logic         req_size_word;
  logic [31:0]  req_data;
  logic         rsp_valid;
  logic [31:0]  rsp_data;
  logic         req_valid_miss;
  logic [31:0]  req_addr_miss;
  logic         req_is_store_miss;
  logic [127:0] req_data_miss;
  logic [127:0] rsp_data_miss;
  logic         rsp_valid_miss;

  int errors = 0;
  int checks = 0;

  data_cache_core #(
    .ADDR_W(32), .LINE_W(128), .NUM_LINES(4), .ACC_W(32)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .dcache_ready       (dcache_ready),
    .xcpt_address_fault (xcpt_address_fault),
    .req_valid          (req_valid),
    .req_addr           (req_addr),
    .req_is_store       (req_is_store),
    .req_size_word      (req_size_word),
    .req_data           (req_data),
    .rsp_valid          (rsp_valid),
    .rsp_data           (rsp_data),
    .req_valid_miss     (req_valid_miss),
    .req_addr_miss      (req_addr_miss),
    .req_is_store_miss  (req_is_store_miss),
    .req_data_miss      (req_data_miss),
    .rsp_data_miss      (rsp_data_miss),
    .rsp_valid_miss     (rsp_valid_miss)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [31:0] a, input logic st,
                         input logic wd, input logic [31:0] d);
    req_valid     = v;
    req_addr      = a;
    req_is_store  = st;
    req_size_word = wd;
    req_data      = d;
  endtask

  // Load-miss into a clean/invalid victim, return the given line, wait for IDLE.
  task automatic fill_line(input logic [31:0] a, input logic [127:0] line);
    set_req(1'b1, a, 1'b0, 1'b1, 32'h0);
    step();
    rsp_data_miss  = line;
    rsp_valid_miss = 1'b1;
    step();
    rsp_valid_miss = 1'b0;
    req_valid      = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] LINE_A  = 128'h00000000_00000000_CAFEBABE_11223344;
  localparam logic [127:0] LINE_0  = 128'h00000003_00000002_00000001_00000000;
  localparam logic [127:0] LINE_0M = 128'h00000003_DEADBEEF_00000001_00000000;
  localparam logic [127:0] LINE_40 = 128'h40404040_30303030_20202020_10101010;

  initial begin
    reset          = 1'b0;
    rsp_valid_miss = 1'b0;
    rsp_data_miss  = '0;
    set_req(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #12;
    chk("rst_ready",      {127'b0, dcache_ready},       128'd1);
    chk("rst_rsp_valid",  {127'b0, rsp_valid},          128'd0);
    chk("rst_rsp_data",   {96'b0, rsp_data},            128'd0);
    chk("rst_miss_valid", {127'b0, req_valid_miss},     128'd0);
    chk("rst_fault",      {127'b0, xcpt_address_fault}, 128'd0);
    @(negedge clock);
    reset = 1'b1;
    step();

    // Cold load miss, fill, replay, then same-cycle hit
    set_req(1'b1, 32'h104, 1'b0, 1'b1, 32'h0);
    #1;
    chk("miss_rsp_valid", {127'b0, rsp_valid}, 128'd0);
    step();
    chk("fill_valid",  {127'b0, req_valid_miss},    128'd1);
    chk("fill_addr",   {96'b0, req_addr_miss},      128'h100);
    chk("fill_is_st",  {127'b0, req_is_store_miss}, 128'd0);
    chk("fill_ready",  {127'b0, dcache_ready},      128'd0);
    rsp_data_miss  = LINE_A;
    rsp_valid_miss = 1'b1;
    step();
    rsp_valid_miss = 1'b0;
    chk("replay_rsp_valid", {127'b0, rsp_valid},      128'd1);
    chk("replay_rsp_data",  {96'b0, rsp_data},        128'hCAFEBABE);
    chk("replay_ready",     {127'b0, dcache_ready},   128'd0);
    chk("replay_no_mreq",   {127'b0, req_valid_miss}, 128'd0);
    step();
    chk("hit_rsp_valid", {127'b0, rsp_valid},    128'd1);
    chk("hit_rsp_data",  {96'b0, rsp_data},      128'hCAFEBABE);
    chk("hit_ready",     {127'b0, dcache_ready}, 128'd1);

    // Byte store hit and read-back
    step();
    set_req(1'b1, 32'h101, 1'b1, 1'b0, 32'h000000AB);
    #1;
    chk("stb_rsp_valid", {127'b0, rsp_valid}, 128'd1);
    chk("stb_rsp_data",  {96'b0, rsp_data},   128'd0);
    step();
    set_req(1'b1, 32'h100, 1'b0, 1'b1, 32'h0);
    #1;
    chk("ldw_merged", {96'b0, rsp_data}, 128'h1122AB44);
    step();
    set_req(1'b1, 32'h101, 1'b0, 1'b0, 32'h0);
    #1;
    chk("ldb_merged", {96'b0, rsp_data}, 128'h000000AB);

    // Misaligned word faults; byte at odd offset does not
    step();
    set_req(1'b1, 32'h102, 1'b0, 1'b1, 32'h0);
    #1;
    chk("fault_flag",      {127'b0, xcpt_address_fault}, 128'd1);
    chk("fault_rsp_valid", {127'b0, rsp_valid},          128'd0);
    chk("fault_ready",     {127'b0, dcache_ready},       128'd1);
    step();
    chk("fault_no_mreq",   {127'b0, req_valid_miss},     128'd0);
    chk("fault_ready2",    {127'b0, dcache_ready},       128'd1);
    set_req(1'b1, 32'h103, 1'b0, 1'b0, 32'h0);
    #1;
    chk("byte_nofault", {127'b0, xcpt_address_fault}, 128'd0);
    chk("byte_103",     {96'b0, rsp_data},            128'h00000011);

    // Stray fill response in IDLE is ignored
    step();
    set_req(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rsp_data_miss  = {128{1'b1}};
    rsp_valid_miss = 1'b1;
    step();
    rsp_valid_miss = 1'b0;
    chk("stray_ready", {127'b0, dcache_ready},   128'd1);
    chk("stray_mreq",  {127'b0, req_valid_miss}, 128'd0);
    set_req(1'b1, 32'h104, 1'b0, 1'b1, 32'h0);
    #1;
    chk("stray_hit_valid", {127'b0, rsp_valid}, 128'd1);
    chk("stray_hit_data",  {96'b0, rsp_data},   128'hCAFEBABE);

    // Long fill wait, then reset mid-fill
    step();
    set_req(1'b1, 32'h200, 1'b0, 1'b1, 32'h0);
    step();
    chk("wait_addr", {96'b0, req_addr_miss}, 128'h200);
    for (int i = 0; i < 10; i++) begin
      chk("wait_mreq",  {127'b0, req_valid_miss}, 128'd1);
      chk("wait_ready", {127'b0, dcache_ready},   128'd0);
      step();
    end
    req_valid = 1'b0;
    reset     = 1'b0;
    #1;
    chk("mrst_ready",     {127'b0, dcache_ready},       128'd1);
    chk("mrst_mreq",      {127'b0, req_valid_miss},     128'd0);
    chk("mrst_rsp_valid", {127'b0, rsp_valid},          128'd0);
    chk("mrst_rsp_data",  {96'b0, rsp_data},            128'd0);
    chk("mrst_fault",     {127'b0, xcpt_address_fault}, 128'd0);
    step();
    @(negedge clock);
    reset = 1'b1;
    step();
    set_req(1'b1, 32'h200, 1'b0, 1'b1, 32'h0);
    #1;
    chk("after_rst_miss", {127'b0, rsp_valid}, 128'd0);
    step();
    chk("after_rst_fill", {127'b0, req_valid_miss}, 128'd1);
    chk("after_rst_addr", {96'b0, req_addr_miss},   128'h200);
    req_valid = 1'b0;
    reset     = 1'b0;
    step();
    @(negedge clock);
    reset = 1'b1;
    step();

    // Fill all four lines, dirty line 0, force its eviction
    fill_line(32'h000, LINE_0);
    fill_line(32'h010, {4{32'h00000011}});
    fill_line(32'h020, {4{32'h00000022}});
    fill_line(32'h030, {4{32'h00000033}});
    set_req(1'b1, 32'h008, 1'b1, 1'b1, 32'hDEADBEEF);
    #1;
    chk("stw_rsp_valid", {127'b0, rsp_valid}, 128'd1);
    step();
    set_req(1'b1, 32'h040, 1'b0, 1'b1, 32'h0);
    #1;
    chk("cap_miss", {127'b0, rsp_valid}, 128'd0);
    step();
    chk("evict_valid", {127'b0, req_valid_miss},    128'd1);
    chk("evict_is_st", {127'b0, req_is_store_miss}, 128'd1);
    chk("evict_addr",  {96'b0, req_addr_miss},      128'h000);
    chk("evict_data",  req_data_miss,               LINE_0M);
    chk("evict_ready", {127'b0, dcache_ready},      128'd0);
    step();
    chk("evfill_valid", {127'b0, req_valid_miss},    128'd1);
    chk("evfill_is_st", {127'b0, req_is_store_miss}, 128'd0);
    chk("evfill_addr",  {96'b0, req_addr_miss},      128'h040);
    rsp_data_miss  = LINE_40;
    rsp_valid_miss = 1'b1;
    step();
    rsp_valid_miss = 1'b0;
    req_valid      = 1'b0;
    chk("evrep_valid", {127'b0, rsp_valid}, 128'd1);
    chk("evrep_data",  {96'b0, rsp_data},   128'h10101010);
    step();
    set_req(1'b1, 32'h010, 1'b0, 1'b1, 32'h0);
    #1;
    chk("line1_hit",  {127'b0, rsp_valid}, 128'd1);
    chk("line1_data", {96'b0, rsp_data},   128'h00000011);
    step();
    set_req(1'b1, 32'h000, 1'b0, 1'b1, 32'h0);
    #1;
    chk("evicted_miss", {127'b0, rsp_valid}, 128'd0);
    step();
    chk("rr_fill_valid", {127'b0, req_valid_miss},    128'd1);
    chk("rr_fill_is_st", {127'b0, req_is_store_miss}, 128'd0);
    chk("rr_fill_addr",  {96'b0, req_addr_miss},      128'h000);

    req_valid = 1'b0;
    reset     = 1'b0;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
